// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and encodings for the UART receiver
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

   typedef struct packed {
      logic       bi;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } rx_entry_t;

   localparam int ENTRY_W = $bits(rx_entry_t);

   localparam logic [1:0] DLEN_5 = 2'b00;
   localparam logic [1:0] DLEN_6 = 2'b01;
   localparam logic [1:0] DLEN_7 = 2'b10;
   localparam logic [1:0] DLEN_8 = 2'b11;

   localparam logic [1:0] RXT_FULL    = 2'b00;
   localparam logic [1:0] RXT_HALF    = 2'b01;
   localparam logic [1:0] RXT_QUARTER = 2'b10;
   localparam logic [1:0] RXT_TWO     = 2'b11;

   // Index of the last data bit for a given word-length encoding
   function automatic logic [2:0] last_bit_idx(input logic [1:0] dlen);
      case (dlen)
         DLEN_5:  return 3'd4;
         DLEN_6:  return 3'd5;
         DLEN_7:  return 3'd6;
         DLEN_8:  return 3'd7;
         default: return 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - control and status bundle between register block and UART receiver
interface uart_rx_param_if #(parameter int AW = 4);
   logic          ctrl_en;
   logic [1:0]    ctrl_dlen;
   logic          ctrl_pen;
   logic          ctrl_ep;
   logic          ctrl_sp;
   logic          ctrl_shift_rx;
   logic          ctrl_data_rd;
   logic [1:0]    ctrl_rxt;
   logic          rx_ne;
   logic          rx_busy;
   logic          rx_rxf;
   logic          rx_ov;
   logic          rx_pe;
   logic          rx_fe;
   logic          rx_bi;
   logic [7:0]    rx_data;
   logic [AW:0]   rx_level;
   logic          rx_to;

   modport master (
      output ctrl_en, ctrl_dlen, ctrl_pen, ctrl_ep, ctrl_sp, ctrl_shift_rx, ctrl_data_rd, ctrl_rxt,
      input  rx_ne, rx_busy, rx_rxf, rx_ov, rx_pe, rx_fe, rx_bi, rx_data, rx_level, rx_to
   );

   modport slave (
      input  ctrl_en, ctrl_dlen, ctrl_pen, ctrl_ep, ctrl_sp, ctrl_shift_rx, ctrl_data_rd, ctrl_rxt,
      output rx_ne, rx_busy, rx_rxf, rx_ov, rx_pe, rx_fe, rx_bi, rx_data, rx_level, rx_to
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive FIFO with flush and occupancy level
module uart_rx_fifo #(
   parameter  int FIFO_DEPTH = 16,
   parameter  int W          = 11,
   localparam int AW         = $clog2(FIFO_DEPTH)
) (
   input  logic          pclk,
   input  logic          preset_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [AW:0]  wptr, rptr;
   logic [W-1:0] mem [FIFO_DEPTH];
   logic         do_push, do_pop;

   // A push into a full FIFO is dropped even if a pop happens in the same cycle
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= rptr;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign level = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - UART receiver: majority-vote sampling, parity/framing/break flags, RX FIFO
// Receive timeout present only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int OVS        = 16
) (
   input  logic           pclk,
   input  logic           preset_n,
   input  logic           uart_rx,
   uart_rx_param_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] CNT_S0   = CW'(OVS / 2 - 2);
   localparam logic [CW-1:0] CNT_S1   = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] CNT_VOTE = CW'(OVS / 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

   logic              sync1, uart_sync;
   rx_state_e         state_q, state_d;
   logic [CW-1:0]     cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              s0, s1, par_q, push_q, ov_q;
   rx_entry_t         entry_q, next_entry, head;
   logic              vote, tick_run, vote_tick, end_tick, start_det, frame_done;
   logic [ENTRY_W-1:0] rdata;
   logic [AW:0]       level;
   logic              full, empty;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         sync1     <= 1'b1;
         uart_sync <= 1'b1;
      end else begin
         sync1     <= uart_rx;
         uart_sync <= sync1;
      end
   end

   assign tick_run  = bus.ctrl_shift_rx && (state_q != IDLE);
   assign vote      = (s0 & s1) | (s0 & uart_sync) | (s1 & uart_sync);
   assign vote_tick = tick_run && (cnt == CNT_VOTE);
   assign end_tick  = tick_run && (cnt == CNT_LAST);

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_det  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE:   if (!uart_sync) begin
                    state_d   = START;
                    start_det = 1'b1;
                 end
         START:  if (vote_tick && vote) state_d = IDLE;
                 else if (end_tick)     state_d = DATA;
         DATA:   if (end_tick && bit_cnt == last_bit_idx(bus.ctrl_dlen))
                    state_d = bus.ctrl_pen ? PARITY : STOP;
         PARITY: if (end_tick) state_d = STOP;
         // Returning to IDLE mid-stop lets the next start edge be caught early
         STOP:   if (vote_tick) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                 end
         default: state_d = IDLE;
      endcase
      if (!bus.ctrl_en) begin
         state_d    = IDLE;
         start_det  = 1'b0;
         frame_done = 1'b0;
      end
   end

   always_comb begin
      next_entry.data = shreg;
      next_entry.fe   = ~vote;
      if (!bus.ctrl_pen)    next_entry.pe = 1'b0;
      else if (bus.ctrl_sp) next_entry.pe = (par_q != ~bus.ctrl_ep);
      else                  next_entry.pe = ((^{shreg, par_q}) != ~bus.ctrl_ep);
      next_entry.bi = (shreg == 8'd0) && (!bus.ctrl_pen || !par_q) && !vote;
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         s0      <= 1'b1;
         s1      <= 1'b1;
         par_q   <= 1'b0;
         push_q  <= 1'b0;
         entry_q <= '0;
      end else if (!bus.ctrl_en) begin
         cnt     <= '0;
         bit_cnt <= '0;
         push_q  <= 1'b0;
      end else begin
         push_q <= frame_done;
         if (frame_done) entry_q <= next_entry;
         if (start_det) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
         end else if (tick_run) begin
            cnt <= end_tick ? '0 : cnt + 1'b1;
            if (cnt == CNT_S0) s0 <= uart_sync;
            if (cnt == CNT_S1) s1 <= uart_sync;
            if (vote_tick && state_q == DATA)   shreg[bit_cnt] <= vote;
            if (vote_tick && state_q == PARITY) par_q <= vote;
            if (end_tick && state_q == DATA)    bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // Overrun set takes priority over the clear from a read in the same cycle
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n)                ov_q <= 1'b0;
      else if (push_q && full)      ov_q <= 1'b1;
      else if (bus.ctrl_data_rd)    ov_q <= 1'b0;
   end

   uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
      .pclk     (pclk),
      .preset_n (preset_n),
      .flush    (!bus.ctrl_en),
      .push     (push_q),
      .wdata    (entry_q),
      .pop      (bus.ctrl_data_rd),
      .rdata    (rdata),
      .level    (level),
      .full     (full),
      .empty    (empty)
   );

   assign head = rx_entry_t'(rdata);

   always_comb begin
      bus.rx_rxf = 1'b0;
      case (bus.ctrl_rxt)
         RXT_FULL:    bus.rx_rxf = full;
         RXT_HALF:    bus.rx_rxf = (level >= (AW+1)'(FIFO_DEPTH / 2));
         RXT_QUARTER: bus.rx_rxf = (level >= (AW+1)'(FIFO_DEPTH / 4));
         RXT_TWO:     bus.rx_rxf = (level >= (AW+1)'(2));
         default:     bus.rx_rxf = 1'b0;
      endcase
   end

   assign bus.rx_ne    = !empty;
   assign bus.rx_busy  = (state_q != IDLE);
   assign bus.rx_ov    = ov_q;
   assign bus.rx_level = level;
   assign bus.rx_data  = empty ? 8'd0 : head.data;
   assign bus.rx_pe    = !empty && head.pe;
   assign bus.rx_fe    = !empty && head.fe;
   assign bus.rx_bi    = !empty && head.bi;

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_LIMIT = 4 * 11 * OVS;
   localparam int TW       = $clog2(TO_LIMIT + 1);
   logic [TW-1:0] to_cnt;
   logic          to_q, pop_ok;

   assign pop_ok = bus.ctrl_data_rd && !empty;

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         to_cnt <= '0;
         to_q   <= 1'b0;
      end else begin
         if (!bus.ctrl_en || start_det || pop_ok || empty)
            to_cnt <= '0;
         else if (bus.ctrl_shift_rx && to_cnt != TW'(TO_LIMIT))
            to_cnt <= to_cnt + 1'b1;
         if (!bus.ctrl_en || start_det || pop_ok)
            to_q <= 1'b0;
         else if (to_cnt == TW'(TO_LIMIT) && !empty)
            to_q <= 1'b1;
      end
   end

   assign bus.rx_to = to_q;
`else
   assign bus.rx_to = 1'b0;
`endif

endmodule
